// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 async read ports, 2 sync write lanes, per-entry written-since-reset bit, saturating write counter.
// Latency: reads are combinational (0 cycles); writes are visible the cycle after the edge (same cycle with forwarding).
// Backpressure: none; every enabled, unsuppressed write is accepted on the edge. Optional macro: REG_FILE_MP_BYPASS_EN.
module reg_file_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rv1,
  output logic              rv2,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  output logic [15:0]       wr_count
);

  localparam int DEPTH   = 1 << ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [15:0]       wr_count_q;

  logic              sup1;
  logic              sup2;
  logic              acc1;
  logic              acc2;
  logic [1:0]        inc;
  logic [16:0]       cnt_sum;
  logic [15:0]       cnt_next;
  logic [DATA_W:0]   port1;
  logic [DATA_W:0]   port2;

  // Qualify the two write lanes: drop writes to the hardwired zero entry,
  // and on an address collision keep only the younger lane 2.
  always_comb begin
    sup1 = ZERO_EN && (wa1 == '0);
    sup2 = ZERO_EN && (wa2 == '0);
    acc2 = we2 && !sup2;
    acc1 = we1 && !sup1 && !(acc2 && (wa1 == wa2));
    inc  = {1'b0, acc1} + {1'b0, acc2};
  end

  // Saturating add of the accepted-write count; the 17th bit flags overflow.
  always_comb begin
    cnt_sum  = {1'b0, wr_count_q} + {15'b0, inc};
    cnt_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  // Storage and valid bits; reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      valid <= '0;
    end else begin
      if (acc1) begin
        mem[wa1]   <= wd1;
        valid[wa1] <= 1'b1;
      end
      if (acc2) begin
        mem[wa2]   <= wd2;
        valid[wa2] <= 1'b1;
      end
    end
  end

  // Accepted-write counter; reset wins over the update in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_count_q <= '0;
    end else begin
      wr_count_q <= cnt_next;
    end
  end

  // One read port: returns {valid, data}. Forwarding (when built in) is
  // applied lane 1 then lane 2 so the younger lane wins; the zero entry
  // override is applied last so it is never forwarded into.
  function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W:0] r;
    r = {valid[ra], mem[ra]};
`ifdef REG_FILE_MP_BYPASS_EN
    if (reset && acc1 && (wa1 == ra)) begin
      r = {1'b1, wd1};
    end
    if (reset && acc2 && (wa2 == ra)) begin
      r = {1'b1, wd2};
    end
`endif
    if (ZERO_EN && (ra == '0)) begin
      r = {1'b1, {DATA_W{1'b0}}};
    end
    return r;
  endfunction

  // Combinational read ports.
  always_comb begin
    port1 = read_port(ra1);
    port2 = read_port(ra2);
  end

  assign rd1      = port1[DATA_W-1:0];
  assign rv1      = port1[DATA_W];
  assign rd2      = port2[DATA_W-1:0];
  assign rv2      = port2[DATA_W];
  assign wr_count = wr_count_q;

endmodule
